// File: rtl/obstacle_collider_if.sv
// obstacle_collider_if: pixel/player inputs and obstacle outputs
// Slave side is the obstacle engine; master side drives counters.
interface obstacle_collider_if;
    logic [9:0] horCnt;
    logic [9:0] verCnt;
    logic [9:0] playerPos;
    logic [5:0] content;
    logic [9:0] objX;
    logic [9:0] objY;
    logic [7:0] score;
    logic       gameOver;

    modport master (
        output horCnt, verCnt, playerPos,
        input  content, objX, objY, score, gameOver
    );

    modport slave (
        input  horCnt, verCnt, playerPos,
        output content, objX, objY, score, gameOver
    );
endinterface

// File: rtl/obstacle_collider.sv
// obstacle_collider: one falling obstacle, spawn, dodge score, collision.
// Optional OBSTACLE_SPEEDUP_EN raises fall speed by 1 every 8 dodges.
module obstacle_collider #(
    parameter int         OBJ_W     = 32,
    parameter int         OBJ_H     = 32,
    parameter int         PLAYER_W  = 40,
    parameter int         PLAYER_Y  = 440,
    parameter int         SPEED     = 2,
    parameter int         MAX_SPEED = 8,
    parameter logic [9:0] SEED      = 10'h2A5,
    parameter logic [5:0] OBJ_COLOR = 6'b110000,
    parameter logic [5:0] HIT_COLOR = 6'b111100
) (
    input logic                 clk,
    input logic                 reset,
    obstacle_collider_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FALL = 2'd1,
        HIT  = 2'd2
    } state_t;

    localparam logic [9:0] SPAWN_MAX = 10'(640 - OBJ_W);

    state_t      state_q;
    logic [9:0]  lfsr_q;
    logic [9:0]  lfsr_d;
    logic [9:0]  verCnt_q;
    logic        tick_q;
    logic        tick_d;
    logic [9:0]  objX_q;
    logic [9:0]  objY_q;
    logic [7:0]  score_q;
    logic        gameOver_q;
    logic [9:0]  spawn_x;
    logic [4:0]  spd;
    logic [10:0] ny;
    logic        hit;
    logic        in_x;
    logic        in_y;

    // LFSR step, vblank-entry detect and spawn x folding
    always_comb begin
        lfsr_d  = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};
        tick_d  = (bus.verCnt == 10'd480) && (verCnt_q != 10'd480);
        spawn_x = (lfsr_q >= SPAWN_MAX) ? (lfsr_q - SPAWN_MAX) : lfsr_q;
    end

`ifdef OBSTACLE_SPEEDUP_EN
    logic [4:0] spd_sum;
    // Speed grows with the dodge count, clamped at the ceiling
    always_comb begin
        spd_sum = 5'(SPEED) + score_q[7:3];
        spd     = (spd_sum > 5'(MAX_SPEED)) ? 5'(MAX_SPEED) : spd_sum;
    end
`else
    // Constant fall speed
    always_comb begin
        spd = 5'(SPEED);
    end
`endif

    // Next y and overlap of the obstacle at that y with the player
    always_comb begin
        ny  = {1'b0, objY_q} + 11'(spd);
        hit = ({1'b0, objX_q} < ({1'b0, bus.playerPos} + 11'(PLAYER_W)))
           && ({1'b0, bus.playerPos} < ({1'b0, objX_q} + 11'(OBJ_W)))
           && ((ny + 11'(OBJ_H)) > 11'(PLAYER_Y));
    end

    // Game FSM with registered position, score and game-over
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            lfsr_q     <= SEED;
            verCnt_q   <= 10'd0;
            tick_q     <= 1'b0;
            objX_q     <= 10'd0;
            objY_q     <= 10'd0;
            score_q    <= 8'd0;
            gameOver_q <= 1'b0;
        end else begin
            lfsr_q   <= lfsr_d;
            verCnt_q <= bus.verCnt;
            tick_q   <= tick_d;
            unique case (state_q)
                IDLE: begin
                    if (tick_q) begin
                        objX_q  <= spawn_x;
                        objY_q  <= 10'd0;
                        state_q <= FALL;
                    end
                end
                FALL: begin
                    if (tick_q) begin
                        if (ny >= 11'd480) begin
                            if (score_q != 8'hFF) begin
                                score_q <= score_q + 8'd1;
                            end
                            objY_q <= 10'd0;
                            objX_q <= spawn_x;
                        end else begin
                            objY_q <= ny[9:0];
                            if (hit) begin
                                gameOver_q <= 1'b1;
                                state_q    <= HIT;
                            end
                        end
                    end
                end
                HIT: begin
                    gameOver_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Pixel layer from registered box and live scan position
    always_comb begin
        in_x = (bus.horCnt >= objX_q)
            && ({1'b0, bus.horCnt} < ({1'b0, objX_q} + 11'(OBJ_W)));
        in_y = (bus.verCnt >= objY_q)
            && ({1'b0, bus.verCnt} < ({1'b0, objY_q} + 11'(OBJ_H)));
        bus.content = 6'd0;
        if (in_x && in_y) begin
            if (state_q == FALL) begin
                bus.content = OBJ_COLOR;
            end else if (state_q == HIT) begin
                bus.content = HIT_COLOR;
            end
        end
    end

    assign bus.objX     = objX_q;
    assign bus.objY     = objY_q;
    assign bus.score    = score_q;
    assign bus.gameOver = gameOver_q;
endmodule

// File: tb/tb_obstacle_collider.sv
// tb_obstacle_collider: directed vectors for spawn, fall, dodge, hit.
// Pixel and overlap cases come from tables; FSM runs are hand sequences.
module tb_obstacle_collider;
    logic clk;
    logic reset;
    logic [9:0] m;
    int nchk;
    int nerr;

    obstacle_collider_if bus();

    obstacle_collider dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int dx;
        int dy;
        bit in;
    } pix_t;

    typedef struct {
        int off;
        bit hit;
    } col_t;

    pix_t pix_tab[7];
    col_t col_tab[5];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: Fibonacci, taps 10 and 7
    always @(posedge clk) begin
        if (reset) m <= 10'h2A5;
        else m <= {m[8:0], m[9] ^ m[6]};
    end

    task automatic chk(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic frame(output logic [9:0] l);
        @(negedge clk);
        bus.verCnt = 10'd479;
        @(negedge clk);
        bus.verCnt = 10'd480;
        @(posedge clk);
        #1 l = m;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        reset = 1'b1;
        bus.verCnt = 10'd0;
        bus.horCnt = 10'd0;
        repeat (n) @(posedge clk);
        #1;
        chk("rst_objX", bus.objX, 0);
        chk("rst_objY", bus.objY, 0);
        chk("rst_score", bus.score, 0);
        chk("rst_gameOver", bus.gameOver, 0);
        chk("rst_content", bus.content, 0);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pix_check(input string tag, input logic [5:0] col);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus.horCnt = bus.objX + 10'(pix_tab[i].dx);
            bus.verCnt = bus.objY + 10'(pix_tab[i].dy);
            #1;
            chk(tag, bus.content, pix_tab[i].in ? int'(col) : 0);
        end
    endtask

    task automatic spawn();
        logic [9:0] l;
        int ex;
        frame(l);
        ex = (l >= 10'd608) ? int'(l) - 608 : int'(l);
        chk("spawn_x", bus.objX, ex);
        chk("spawn_y", bus.objY, 0);
        chk("spawn_gameOver", bus.gameOver, 0);
        pix_check("spawn_pix", 6'b110000);
    endtask

    initial begin
        logic [9:0] l;
        int tries;
        int ey;
        int sc;
        int spd;
        int fx;
        bit done;
        nchk = 0;
        nerr = 0;
        pix_tab[0] = '{0, 0, 1'b1};
        pix_tab[1] = '{31, 31, 1'b1};
        pix_tab[2] = '{32, 0, 1'b0};
        pix_tab[3] = '{-1, 0, 1'b0};
        pix_tab[4] = '{0, 32, 1'b0};
        pix_tab[5] = '{0, -1, 1'b0};
        pix_tab[6] = '{15, 16, 1'b1};
        col_tab[0] = '{0, 1'b1};
        col_tab[1] = '{40, 1'b0};
        col_tab[2] = '{39, 1'b1};
        col_tab[3] = '{-31, 1'b1};
        col_tab[4] = '{-32, 1'b0};

        reset = 1'b1;
        bus.horCnt = 10'd0;
        bus.verCnt = 10'd0;
        bus.playerPos = 10'd0;
        do_reset(3);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            bus.verCnt = 10'(i * 23);
            bus.horCnt = 10'(i * 5);
            #1;
            chk("idle_objX", bus.objX, 0);
            chk("idle_content", bus.content, 0);
        end
        chk("idle_score", bus.score, 0);

        for (int c = 0; c < 5; c++) begin
            tries = 0;
            do begin
                do_reset(1 + tries);
                repeat (tries * 7) @(posedge clk);
                spawn();
                tries++;
            end while (bus.objX < 10'd40 && tries < 20);
            if (bus.objX < 10'd40) chk("spawn_range", bus.objX, 40);
            bus.playerPos = bus.objX - 10'(col_tab[c].off);
            ey = 0;
            done = 1'b0;
            for (int f = 0; f < 260 && !done; f++) begin
                frame(l);
                ey += 2;
                if (ey >= 480) begin
                    chk("dodge_score", bus.score, 1);
                    chk("dodge_y", bus.objY, 0);
                    chk("dodge_gameOver", bus.gameOver, 0);
                    done = 1'b1;
                end else begin
                    chk("fall_y", bus.objY, ey);
                    if (col_tab[c].hit && ey >= 410) begin
                        chk("hit_gameOver", bus.gameOver, 1);
                        chk("hit_y", bus.objY, 410);
                        done = 1'b1;
                    end else begin
                        chk("fall_gameOver", bus.gameOver, 0);
                    end
                end
            end
            if (!done) chk("fall_timeout", 0, 1);
            if (col_tab[c].hit) begin
                fx = int'(bus.objX);
                frame(l);
                frame(l);
                chk("frozen_y", bus.objY, 410);
                chk("frozen_x", bus.objX, fx);
                chk("frozen_gameOver", bus.gameOver, 1);
                chk("frozen_score", bus.score, 0);
                pix_check("hit_pix", 6'b111100);
            end
        end
        do_reset(1);

        spawn();
        ey = 0;
        sc = 0;
        done = 1'b0;
        for (int f = 0; f < 3000 && !done; f++) begin
            bus.playerPos = (bus.objX < 10'd300) ? 10'd500 : 10'd0;
`ifdef OBSTACLE_SPEEDUP_EN
            spd = 2 + sc / 8;
            if (spd > 8) spd = 8;
`else
            spd = 2;
`endif
            frame(l);
            ey += spd;
            if (ey >= 480) begin
                ey = 0;
                sc++;
                chk("run_score", bus.score, sc);
            end
            chk("run_y", bus.objY, ey);
            if (sc == 8 && ey == 0) done = 1'b1;
        end
        if (!done) chk("run_timeout", 0, 1);
        bus.playerPos = (bus.objX < 10'd300) ? 10'd500 : 10'd0;
        frame(l);
`ifdef OBSTACLE_SPEEDUP_EN
        chk("speed_step", bus.objY, 3);
`else
        chk("speed_step", bus.objY, 2);
`endif
        chk("speed_gameOver", bus.gameOver, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
